// File: rtl/step_dir_decoder_if.sv
// Bus between a step/dir pulse source and step_dir_decoder: sampled
// inputs toward the decoder, position/move status back to the source.
interface step_dir_decoder_if #(
    parameter int POS_BITS   = 16,
    parameter int COUNT_BITS = 8,
    parameter int WIDTH_BITS = 8
);
    logic                         clk_en;
    logic                         step_in;
    logic                         dir_in;
    logic                         clear_pos;
    logic signed [POS_BITS-1:0]   position;
    logic signed [COUNT_BITS-1:0] last_move;
    logic [WIDTH_BITS-1:0]        high_width;
    logic                         busy;
    logic                         move_done;
    logic                         dir_err;

    modport master (
        output clk_en, step_in, dir_in, clear_pos,
        input  position, last_move, high_width, busy, move_done, dir_err
    );

    modport slave (
        input  clk_en, step_in, dir_in, clear_pos,
        output position, last_move, high_width, busy, move_done, dir_err
    );
endinterface

// File: rtl/step_dir_decoder.sv
// Step/direction pulse decoder: accumulates a signed position, groups steps
// into moves ended by an idle timeout, and measures step pulse high width.
module step_dir_decoder #(
    parameter int POS_BITS   = 16,
    parameter int COUNT_BITS = 8,
    parameter int WIDTH_BITS = 8,
    parameter int IDLE_TICKS = 16
) (
    input logic               clk,
    input logic               reset,
    step_dir_decoder_if.slave bus
);
    localparam int IDLE_W = $clog2(IDLE_TICKS + 1);
    localparam logic signed [COUNT_BITS-1:0] CNT_MAX = {1'b0, {(COUNT_BITS-1){1'b1}}};
    localparam logic signed [COUNT_BITS-1:0] CNT_MIN = -CNT_MAX;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t                       state_q, state_d;
    logic                         step_s1_q, step_s1_d, step_s2_q, step_s2_d;
    logic                         dir_s1_q, dir_s1_d, dir_s2_q, dir_s2_d;
    logic                         step_prev_q, step_prev_d;
    logic                         move_dir_q, move_dir_d;
    logic signed [COUNT_BITS-1:0] move_cnt_q, move_cnt_d;
    logic signed [COUNT_BITS-1:0] last_move_q, last_move_d;
    logic signed [POS_BITS-1:0]   position_q, position_d;
    logic [WIDTH_BITS-1:0]        width_cnt_q, width_cnt_d;
    logic [WIDTH_BITS-1:0]        high_width_q, high_width_d;
    logic [IDLE_W-1:0]            idle_cnt_q, idle_cnt_d;
    logic                         move_done_q, move_done_d;
    logic                         dir_err_q, dir_err_d;
    logic                         rise, fall, count_step;

    assign rise = bus.clk_en & step_s2_q & ~step_prev_q;
    assign fall = bus.clk_en & ~step_s2_q & step_prev_q;

    always_comb begin
        state_d      = state_q;
        step_s1_d    = bus.step_in;
        step_s2_d    = step_s1_q;
        dir_s1_d     = bus.dir_in;
        dir_s2_d     = dir_s1_q;
        step_prev_d  = step_prev_q;
        move_dir_d   = move_dir_q;
        move_cnt_d   = move_cnt_q;
        last_move_d  = last_move_q;
        position_d   = position_q;
        width_cnt_d  = width_cnt_q;
        high_width_d = high_width_q;
        idle_cnt_d   = idle_cnt_q;
        move_done_d  = 1'b0;
        dir_err_d    = dir_err_q;
        count_step   = 1'b0;

        if (bus.clk_en) begin
            step_prev_d = step_s2_q;
            if (bus.clear_pos) begin
                position_d = '0;
                dir_err_d  = 1'b0;
            end
            // Inside a move a direction change is flagged and then adopted,
            // so later steps count in the new direction.
            if (state_q != IDLE && dir_s2_q != move_dir_q) begin
                dir_err_d  = 1'b1;
                move_dir_d = dir_s2_q;
            end
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d     = HIGH;
                        move_dir_d  = dir_s2_q;
                        move_cnt_d  = dir_s2_q ? '1 : COUNT_BITS'(1);
                        width_cnt_d = WIDTH_BITS'(1);
                        count_step  = 1'b1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d      = LOW;
                        high_width_d = width_cnt_q;
                        idle_cnt_d   = '0;
                    end else if (width_cnt_q != '1) begin
                        width_cnt_d = width_cnt_q + WIDTH_BITS'(1);
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_d     = HIGH;
                        width_cnt_d = WIDTH_BITS'(1);
                        count_step  = 1'b1;
                        if (dir_s2_q) begin
                            if (move_cnt_q != CNT_MIN) move_cnt_d = move_cnt_q - COUNT_BITS'(1);
                        end else if (move_cnt_q != CNT_MAX) begin
                            move_cnt_d = move_cnt_q + COUNT_BITS'(1);
                        end
                    end else if (idle_cnt_q == IDLE_W'(IDLE_TICKS - 1)) begin
                        state_d     = IDLE;
                        last_move_d = move_cnt_q;
                        move_done_d = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            // Applied after clear so a coincident clear and step leaves +/-1.
            if (count_step) begin
                position_d = dir_s2_q ? position_d - POS_BITS'(1) : position_d + POS_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            step_s1_q    <= 1'b0;
            step_s2_q    <= 1'b0;
            dir_s1_q     <= 1'b0;
            dir_s2_q     <= 1'b0;
            step_prev_q  <= 1'b0;
            move_dir_q   <= 1'b0;
            move_cnt_q   <= '0;
            last_move_q  <= '0;
            position_q   <= '0;
            width_cnt_q  <= '0;
            high_width_q <= '0;
            idle_cnt_q   <= '0;
            move_done_q  <= 1'b0;
            dir_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_s1_q    <= step_s1_d;
            step_s2_q    <= step_s2_d;
            dir_s1_q     <= dir_s1_d;
            dir_s2_q     <= dir_s2_d;
            step_prev_q  <= step_prev_d;
            move_dir_q   <= move_dir_d;
            move_cnt_q   <= move_cnt_d;
            last_move_q  <= last_move_d;
            position_q   <= position_d;
            width_cnt_q  <= width_cnt_d;
            high_width_q <= high_width_d;
            idle_cnt_q   <= idle_cnt_d;
            move_done_q  <= move_done_d;
            dir_err_q    <= dir_err_d;
        end
    end

    assign bus.position   = position_q;
    assign bus.last_move  = last_move_q;
    assign bus.high_width = high_width_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.move_done  = move_done_q;
    assign bus.dir_err    = dir_err_q;
endmodule

// File: doc/step_dir_decoder.md
STEP_DIR_DECODER -- requirements
Module: step_dir_decoder

Interface
REQ-001 Parameter POS_BITS, default 16, width of the accumulated signed position.
REQ-002 Parameter COUNT_BITS, default 8, width of the signed per-move step count.
REQ-003 Parameter WIDTH_BITS, default 8, width of the measured pulse-high width.
REQ-004 Parameter IDLE_TICKS, default 16, number of step-low clk_en ticks that ends a move.
REQ-005 clk  in  1  system clock; all state SHALL update on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 clk_en  in  1  sampling/tick enable; one tick equals one pulse-width unit.
REQ-008 step_in  in  1  step pulse line; a rising edge is one step.
REQ-009 dir_in  in  1  direction: 0 = positive (increment), 1 = negative (decrement).
REQ-010 clear_pos  in  1  single-cycle request that zeroes position and clears dir_err.
REQ-011 position  out  POS_BITS  signed two's-complement accumulated step position.
REQ-012 last_move  out  COUNT_BITS  signed step count of the most recently completed move.
REQ-013 high_width  out  WIDTH_BITS  high time of the most recent step pulse, in clk_en ticks.
REQ-014 busy  out  1  high while a move is in progress (state HIGH or LOW).
REQ-015 move_done  out  1  one-clk pulse when a move ends.
REQ-016 dir_err  out  1  sticky flag: dir_in changed during a move.

Function
REQ-017 step_in and dir_in SHALL pass through a 2-flop synchronizer clocked every clk (not gated by clk_en).
REQ-018 Synchronized inputs SHALL be sampled only on clk_en; edges are detected against the previous clk_en sample of step.
REQ-019 FSM states: IDLE, HIGH, LOW; all transitions occur only on clk_en cycles.
REQ-020 IDLE: on rising edge -> HIGH; latch move_dir = dir; move_cnt = +1 or -1; busy asserts next clk.
REQ-021 HIGH: width counter starts at 1 on the rising-edge tick, increments per tick, saturates at all-ones; on falling edge high_width <= counter; -> LOW; idle counter <= 0.
REQ-022 LOW: on rising edge -> HIGH, step counted, width counter restarts at 1; otherwise idle counter increments.
REQ-023 LOW: when idle counter reaches IDLE_TICKS -> IDLE; last_move <= move_cnt; move_done pulses for exactly one clk.
REQ-024 Each counted rising edge SHALL update position by +1 (dir 0) or -1 (dir 1) in the same clk; position wraps modulo 2^POS_BITS.
REQ-025 move_cnt SHALL saturate at +(2^(COUNT_BITS-1)-1) and -(2^(COUNT_BITS-1)-1); position keeps counting past saturation.
REQ-026 Sampled dir differing from move_dir in HIGH or LOW SHALL set dir_err; counting continues with the new dir.
REQ-027 clear_pos and a counted edge in the same clk SHALL yield position = +1 or -1 (clear first, then step).
REQ-028 clear_pos SHALL NOT affect FSM state, move_cnt, last_move or high_width.
REQ-029 A step pulse still high when the move times out cannot occur; the idle timeout runs only in LOW.
REQ-030 With clk_en low, all state and outputs SHALL hold (except the synchronizer and the move_done deassert).

Reset
REQ-031 Reset SHALL force state IDLE; position, last_move, high_width, move_cnt and counters to 0; busy, move_done and dir_err to 0; synchronizer flops to 0.
REQ-032 Reset asserted mid-move SHALL abandon the move without a move_done pulse; the first rising edge after reset starts a new move.

Verification
REQ-033 clk_en every clk, 5 pulses, 3 ticks high / 3 ticks low, dir=0 -> position=5, last_move=5, high_width=3, one move_done pulse IDLE_TICKS ticks after the last fall.
REQ-034 Same stimulus with dir=1, then 2 pulses with dir=0 -> last_move=-5, then last_move=2, position=-3.
REQ-035 position=32767, one step with dir=0 -> position=-32768; 130-step move -> last_move=127.
REQ-036 dir toggled between pulses 2 and 3 of a move -> dir_err=1; clear_pos -> dir_err=0, position=0.
REQ-037 clear_pos coincident with a counted rising edge, dir=1 -> position=-1.
REQ-038 clk_en every 4th clk, 300-tick pulse high -> high_width=255; reset mid-move -> all outputs 0, no move_done.
